// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg
// Shared constants and types for the display frame store.
//   COLOR_*        : 2-bit cell encodings, {red, green}
//   frame_state_t  : fill-engine state encoding
//   DISPLAY_ADDR_W : default cell address width (64 cells)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int DISPLAY_ADDR_W = 6;

  localparam logic [1:0] COLOR_OFF   = 2'b00;
  localparam logic [1:0] COLOR_GREEN = 2'b01;
  localparam logic [1:0] COLOR_RED   = 2'b10;
  localparam logic [1:0] COLOR_BOTH  = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/display_cell_counter.sv
// ============================================================================
// display_cell_counter
// Up/down counter tracking how many cells have one colour bit set.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : a cell is being written this cycle
//   old_bit   : colour bit currently stored in that cell
//   new_bit   : colour bit being written
//   count     : number of cells with the bit set
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module display_cell_counter #(
  parameter int               CNT_W     = 7,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             old_bit,
  input  logic             new_bit,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
    end else if (en && (old_bit != new_bit)) begin
      // Only a changing bit moves the count: 0->1 adds, 1->0 removes.
      if (new_bit) count <= count + 1'b1;
      else         count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_frame_ram.sv
// ============================================================================
// display_frame_ram
// Frame store feeding the LED matrix scanner: 2**ADDR_W cells of {red,green},
// combinational read port, ready/valid single-cell write port and a
// whole-frame fill engine that has priority over writes.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   rd_addr / rd_data   : zero-latency scanner read
//   wr_valid/wr_ready/wr_addr/wr_data : single-cell write handshake
//   fill_req/fill_data  : start a full-frame fill with the given colour
//   busy                : fill engine running
//   fill_done           : one-cycle pulse in the first idle cycle after a fill
// Optional build macro DISPLAY_FRAME_RAM_COUNT_EN adds red_count/green_count,
// the number of cells with each colour bit lit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module display_frame_ram
  import display_pkg::*;
#(
  parameter int         ADDR_W        = DISPLAY_ADDR_W,
  parameter logic [1:0] FILL_ON_RESET = COLOR_OFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic              fill_req,
  input  logic [1:0]        fill_data,
  output logic              busy,
  output logic              fill_done
`ifdef DISPLAY_FRAME_RAM_COUNT_EN
  ,
  output logic [ADDR_W:0]   red_count,
  output logic [ADDR_W:0]   green_count
`endif
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // Cells packed into one vector so the whole frame can be reset in one step.
  logic [2*DEPTH-1:0] mem;

  frame_state_t      state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [1:0]        fill_val;

  logic              we;
  logic [ADDR_W-1:0] we_addr;
  logic [1:0]        we_data;

  // Fill request wins over a same-cycle write; the writer keeps holding.
  assign wr_ready = (state == IDLE) && !fill_req;

  assign rd_data = mem[{rd_addr, 1'b0} +: 2];

  // Single write port shared by the fill engine and the external writer.
  always_comb begin
    we      = 1'b0;
    we_addr = wr_addr;
    we_data = wr_data;
    if (state == FILL) begin
      we      = 1'b1;
      we_addr = fill_cnt;
      we_data = fill_val;
    end else if (wr_valid && wr_ready) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= {DEPTH{FILL_ON_RESET}};
    end else if (we) begin
      mem[{we_addr, 1'b0} +: 2] <= we_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      fill_val  <= COLOR_OFF;
      busy      <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fill_done <= 1'b0;
          if (fill_req) begin
            fill_val <= fill_data;
            fill_cnt <= '0;
            busy     <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          // Counter wraps to zero here, leaving it ready for the next fill.
          if (fill_cnt == LAST_ADDR) begin
            busy      <= 1'b0;
            fill_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPLAY_FRAME_RAM_COUNT_EN
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0] old_cell;
  assign old_cell = mem[{we_addr, 1'b0} +: 2];

  display_cell_counter #(
    .CNT_W     (ADDR_W + 1),
    .RESET_VAL (FILL_ON_RESET[1] ? FULL_CNT : '0)
  ) u_red_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (we),
    .old_bit (old_cell[1]),
    .new_bit (we_data[1]),
    .count   (red_count)
  );

  display_cell_counter #(
    .CNT_W     (ADDR_W + 1),
    .RESET_VAL (FILL_ON_RESET[0] ? FULL_CNT : '0)
  ) u_green_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (we),
    .old_bit (old_cell[0]),
    .new_bit (we_data[0]),
    .count   (green_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_display_frame_ram.sv
// ============================================================================
// tb_display_frame_ram
// Scoreboard bench for display_frame_ram: stimulus pushes per-cycle expected
// outputs from a frame-level model; a negedge monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_frame_ram;

  localparam int         ADDR_W = 6;
  localparam int         DEPTH  = 64;
  localparam logic [1:0] RST_V  = 2'b00;

  logic              clk = 1'b1;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic              fill_req;
  logic [1:0]        fill_data;
  logic              busy;
  logic              fill_done;
`ifdef DISPLAY_FRAME_RAM_COUNT_EN
  logic [ADDR_W:0]   red_count;
  logic [ADDR_W:0]   green_count;
`endif

  display_frame_ram #(
    .ADDR_W        (ADDR_W),
    .FILL_ON_RESET (RST_V)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .fill_req    (fill_req),
    .fill_data   (fill_data),
    .busy        (busy),
    .fill_done   (fill_done)
`ifdef DISPLAY_FRAME_RAM_COUNT_EN
    ,
    .red_count   (red_count),
    .green_count (green_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rd;
    logic       bsy;
    logic       done;
    logic       rdy;
    int         red;
    int         green;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Frame-level reference: cell contents plus an in-progress fill.
  logic [1:0]        model [DEPTH];
  bit                m_busy;
  bit                m_done;
  int                m_idx;
  logic [1:0]        m_val;
  // Pending write held by the requester until accepted.
  bit                pend;
  logic [ADDR_W-1:0] p_addr;
  logic [1:0]        p_data;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = RST_V;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
  endfunction

  function automatic void check(string name, int act, int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("rd_data",   int'(rd_data),   int'(e.rd));
      check("busy",      int'(busy),      int'(e.bsy));
      check("fill_done", int'(fill_done), int'(e.done));
      check("wr_ready",  int'(wr_ready),  int'(e.rdy));
`ifdef DISPLAY_FRAME_RAM_COUNT_EN
      check("red_count",   int'(red_count),   e.red);
      check("green_count", int'(green_count), e.green);
`endif
    end
  end

  // One clock cycle: drive inputs, predict outputs, advance the model at the edge.
  task automatic step(input logic [ADDR_W-1:0] ra, input bit fr,
                      input logic [1:0] fd, input bit r);
    exp_t e;
    rst       = r;
    rd_addr   = ra;
    fill_req  = fr;
    fill_data = fd;
    wr_valid  = pend;
    wr_addr   = p_addr;
    wr_data   = p_data;
    if (r) model_reset();
    e.rd    = model[ra];
    e.bsy   = m_busy;
    e.done  = m_done;
    e.rdy   = !m_busy && !fr;
    e.red   = 0;
    e.green = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e.red   += int'(model[i][1]);
      e.green += int'(model[i][0]);
    end
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_busy) begin
      model[m_idx] = m_val;
      m_idx++;
      m_done = (m_idx == DEPTH);
      if (m_done) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (fr) begin
        m_busy = 1'b1;
        m_idx  = 0;
        m_val  = fd;
      end else if (pend) begin
        model[p_addr] = p_data;
        pend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(ADDR_W'($urandom_range(0, DEPTH - 1)), 1'b0, 2'b00, 1'b0);
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) step(ADDR_W'(i), 1'b0, 2'b00, 1'b0);
  endtask

  task automatic request_write(input logic [ADDR_W-1:0] a, input logic [1:0] d);
    pend   = 1'b1;
    p_addr = a;
    p_data = d;
  endtask

  task automatic hold_until_written(input int budget);
    int n = 0;
    while (pend && n < budget) begin
      step(p_addr, 1'b0, 2'b00, 1'b0);
      n++;
    end
    if (pend) begin
      vectors++;
      miscompares++;
      $display("FAIL write_timeout: write still pending after %0d cycles, required accepted", budget);
      pend = 1'b0;
    end
  endtask

  initial begin
    pend   = 1'b0;
    p_addr = '0;
    p_data = 2'b00;
    m_val  = 2'b00;
    model_reset();
    rst = 1'b1; rd_addr = '0; fill_req = 1'b0; fill_data = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    step('0, 1'b0, 2'b00, 1'b1);
    step('0, 1'b0, 2'b00, 1'b1);
    // Reset contents across the whole frame.
    sweep();

    // Single write: old value in the write cycle, new value after.
    request_write(6'd9, 2'b10);
    step(6'd9, 1'b0, 2'b00, 1'b0);
    step(6'd9, 1'b0, 2'b00, 1'b0);
    sweep();

    // Full fill with green.
    step(6'd0, 1'b1, 2'b01, 1'b0);
    idle(70);
    sweep();

    // Fill and write collide: write waits and lands on the fill_done cycle.
    request_write(6'd3, 2'b11);
    step(6'd3, 1'b1, 2'b10, 1'b0);
    hold_until_written(100);
    idle(3);
    sweep();

    // Reset in the middle of a fill.
    step(6'd0, 1'b1, 2'b11, 1'b0);
    idle(20);
    step(6'd5, 1'b0, 2'b00, 1'b1);
    step(6'd5, 1'b0, 2'b00, 1'b0);
    idle(70);
    sweep();

    // Fill all-on, then clear red-only on cell 0 (colour counters).
    step(6'd0, 1'b1, 2'b11, 1'b0);
    idle(66);
    request_write(6'd0, 2'b10);
    hold_until_written(10);
    idle(2);

    // Back-to-back fills with fill_req held high.
    for (int i = 0; i < 140; i++) step(ADDR_W'(i % DEPTH), 1'b1, 2'(i / 65), 1'b0);
    idle(70);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 2) == 0)
        request_write(ADDR_W'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3)));
      step(ADDR_W'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 60) == 0),
           2'($urandom_range(0, 3)), 1'b0);
    end
    hold_until_written(100);
    idle(70);
    sweep();

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
